sd_spi_datapath: RTL
====================

SD_SPI_DATAPATH -- requirements
Module: sd_spi_datapath

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (legal range 2..255).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port n_rst  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port cs_in  input  1  chip-select request from the controller (active-low).
REQ-005 SHALL have port load_command  input  1  load `command` into the TX shift register.
REQ-006 SHALL have port command  input  48  SD command frame, sent MSB first.
REQ-007 SHALL have port shift_command  input  1  shift the TX register on SCLK falling edges.
REQ-008 SHALL have port shift_read  input  1  shift MISO into the RX register on SCLK rising edges.
REQ-009 SHALL have port miso  input  1  serial data from the card (asynchronous).
REQ-010 SHALL have port sclk  output  1  SPI clock to the card (mode 0, idle low).
REQ-011 SHALL have port mosi  output  1  serial data to the card.
REQ-012 SHALL have port sd_cs  output  1  registered chip select to the card.
REQ-013 SHALL have port rising_edge_sclk  output  1  one-clk pulse in the cycle SCLK goes 0->1.
REQ-014 SHALL have port falling_edge_sclk  output  1  one-clk pulse in the cycle SCLK goes 1->0.
REQ-015 SHALL have port sd_rsp_msg  output  8  last 8 bits received, newest bit in bit 0.
REQ-016 SHALL have port byte_done  output  1  one-clk pulse when the 8th bit of a byte is shifted in.

Function
REQ-017 SHALL run a divider counter 0..CLK_DIV-1 continuously. When the counter is at CLK_DIV-1, it wraps to 0 and sclk toggles on the next edge.
REQ-018 SHALL assert rising_edge_sclk combinationally when the counter is at CLK_DIV-1 and sclk=0, and falling_edge_sclk when the counter is at CLK_DIV-1 and sclk=1.
REQ-019 SHALL give SCLK a period of 2*CLK_DIV clk cycles at 50% duty.
REQ-020 SHALL, on load_command=1, set tx_reg <= command on the next edge. Load takes priority over any simultaneous shift.
REQ-021 SHALL, when shift_command=1, falling_edge_sclk=1 and load_command=0, set tx_reg <= {tx_reg[46:0],1'b1}.
REQ-022 SHALL drive mosi = tx_reg[47] when shift_command=1, else 1. The first bit is therefore valid before the first rising edge after load.
REQ-023 SHALL pass miso through a two-flop synchronizer. miso_s is the second-stage output.
REQ-024 SHALL, when shift_read=1 and rising_edge_sclk=1, set rx_reg <= {rx_reg[6:0],miso_s} and increment the 3-bit bit_cnt (modulo 8).
REQ-025 SHALL assert byte_done in the cycle after the shift that takes bit_cnt from 7 to 0.
REQ-026 SHALL drive sd_rsp_msg = rx_reg. This value is updated in the same cycle an external counter enabled by rising_edge_sclk increments.
REQ-027 SHALL clear bit_cnt to 0, and set rx_reg to 8'hFF, whenever shift_read=0. This gives a fresh byte alignment on each read phase.
REQ-028 SHALL register sd_cs <= cs_in every clk cycle (one cycle of latency).
REQ-029 SHALL allow shift_command and shift_read to be asserted together: both shifts occur independently on their respective edges.

Reset
REQ-030 SHALL, while n_rst=0, force: divider counter=0, sclk=0, tx_reg=48'hFFFF_FFFF_FFFF, rx_reg=8'hFF, bit_cnt=0, synchronizer flops=1, sd_cs=1, byte_done=0.
REQ-031 SHALL resume dividing from counter 0 after reset deassertion; the first rising_edge_sclk occurs CLK_DIV-1 cycles after release.
REQ-032 SHALL, on reset mid-transfer, abandon any partial frame or byte; no pulse outputs are asserted during reset.

Verification
REQ-033 Divider: CLK_DIV=4, hold for 40 clk -> sclk period 8 clk; exactly one rising and one falling pulse per period, never in the same cycle.
REQ-034 TX frame: load 48'h500000000055, then shift_command for 48 rising edges -> mosi sampled at each rising edge equals 0x500000000055 MSB first; mosi=1 after shift_command drops.
REQ-035 RX byte: shift_read with miso driving 0x00 then 0xA5 MSB first -> sd_rsp_msg=8'h00 after 8 rising edges and 8'hA5 after 16; byte_done pulses twice.
REQ-036 Load-vs-shift collision: load_command asserted in the same cycle as a falling pulse with shift_command=1 -> tx_reg equals the new command, unshifted.
REQ-037 Reset mid-operation: drop n_rst after 20 TX bits and 3 RX bits -> all REQ-030 values hold immediately; the next frame transmits correctly from bit 47.
REQ-038 CS latency: toggle cs_in 1->0->1 -> sd_cs follows one clk later; forced to 1 during reset.

Source files
------------

// File: rtl/sd_spi_datapath.sv
// SPI-mode SD card datapath: SCLK divider, 48-bit command shifter, byte receiver
// with a two-flop MISO synchronizer, and registered chip select.
module sd_spi_datapath #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        cs_in,
  input  logic        load_command,
  input  logic [47:0] command,
  input  logic        shift_command,
  input  logic        shift_read,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        sd_cs,
  output logic        rising_edge_sclk,
  output logic        falling_edge_sclk,
  output logic [7:0]  sd_rsp_msg,
  output logic        byte_done
);

  localparam int unsigned CNT_W     = 8;
  localparam int unsigned FRAME_W   = 48;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BIT_CNT_W = 3;

  logic [CNT_W-1:0]     div_cnt_q, div_cnt_d;
  logic                 sclk_q, sclk_d;
  logic [FRAME_W-1:0]   tx_q, tx_d;
  logic [BYTE_W-1:0]    rx_q, rx_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 miso_s1_q, miso_s1_d;
  logic                 miso_s2_q, miso_s2_d;
  logic                 sd_cs_q, sd_cs_d;
  logic                 byte_done_q, byte_done_d;
  logic                 div_wrap;

  // Edge strobes fire in the cycle before SCLK actually toggles.
  assign div_wrap          = (div_cnt_q == CNT_W'(CLK_DIV - 1));
  assign rising_edge_sclk  = div_wrap & ~sclk_q;
  assign falling_edge_sclk = div_wrap & sclk_q;

  always_comb begin
    div_cnt_d   = div_cnt_q;
    sclk_d      = sclk_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = 1'b0;
    miso_s1_d   = miso;
    miso_s2_d   = miso_s1_q;
    sd_cs_d     = cs_in;

    if (div_wrap) begin
      div_cnt_d = '0;
      sclk_d    = ~sclk_q;
    end else begin
      div_cnt_d = div_cnt_q + CNT_W'(1);
    end

    // A fresh load always wins over a pending shift.
    if (load_command) begin
      tx_d = command;
    end else if (shift_command && falling_edge_sclk) begin
      tx_d = {tx_q[FRAME_W-2:0], 1'b1};
    end

    // Dropping shift_read re-aligns the byte boundary for the next read phase.
    if (!shift_read) begin
      rx_d      = '1;
      bit_cnt_d = '0;
    end else if (rising_edge_sclk) begin
      rx_d        = {rx_q[BYTE_W-2:0], miso_s2_q};
      bit_cnt_d   = bit_cnt_q + BIT_CNT_W'(1);
      byte_done_d = (bit_cnt_q == '1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      div_cnt_q   <= '0;
      sclk_q      <= 1'b0;
      tx_q        <= '1;
      rx_q        <= '1;
      bit_cnt_q   <= '0;
      miso_s1_q   <= 1'b1;
      miso_s2_q   <= 1'b1;
      sd_cs_q     <= 1'b1;
      byte_done_q <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      sclk_q      <= sclk_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_cnt_q   <= bit_cnt_d;
      miso_s1_q   <= miso_s1_d;
      miso_s2_q   <= miso_s2_d;
      sd_cs_q     <= sd_cs_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign sclk       = sclk_q;
  assign mosi       = shift_command ? tx_q[FRAME_W-1] : 1'b1;
  assign sd_cs      = sd_cs_q;
  assign sd_rsp_msg = rx_q;
  assign byte_done  = byte_done_q;

endmodule
